// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: funct encodings and multiply controller states.
package mips_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN,
        DONE
    } mult_state_t;

    function automatic logic is_mul(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Radix-2 shift-add multiply datapath: operand latch, accumulator,
// sign correction and HI/LO result registers.
module mult_shift_add_dp
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             negate,
    input  logic             commit,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               neg;

    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    // The most-negative operand negates to itself, which read unsigned is 2^(W-1).
    always_comb begin
        mag_rs = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        mag_rt = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        addend = acc[0] ? mcand : {WIDTH{1'b0}};
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prod   = (negate && neg) ? -acc : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (load) begin
                mcand <= mag_rs;
                acc   <= {{WIDTH{1'b0}}, mag_rt};
                neg   <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            end else if (step) begin
                acc <= {sum, acc[WIDTH-1:1]};
            end else if (commit) begin
                acc <= prod;
                hi  <= prod[2*WIDTH-1:WIDTH];
                lo  <= prod[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle mult/multu controller: FSM, iteration counter, pipeline
// stall and mfhi/mflo read port around the shift-add datapath.
module mult_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mult_state_t      state;
    mult_state_t      nxt;
    logic [CNT_W-1:0] count;

    logic accept;
    logic load;
    logic step;
    logic negate;
    logic commit;
    logic is_signed;

    assign accept    = start && is_mul(funct);
    assign is_signed = (funct == FUNCT_MULT);

    always_comb begin
        nxt    = state;
        load   = 1'b0;
        step   = 1'b0;
        negate = 1'b0;
        commit = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    nxt  = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST) begin
                    nxt = SIGN;
                end
            end
            SIGN: begin
                negate = 1'b1;
                commit = 1'b1;
                nxt    = DONE;
            end
            DONE: begin
                if (accept) begin
                    load = 1'b1;
                    nxt  = RUN;
                end else begin
                    nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= nxt;
            if (load) begin
                count <= '0;
            end else if (step) begin
                count <= count + 1'b1;
            end
        end
    end

    assign busy  = (state == RUN) || (state == SIGN);
    assign done  = (state == DONE);
    assign stall = busy & (rd_req | start);

    // HI/LO are written on the edge entering DONE, so a read there sees the new product.
    always_comb begin
        rd_data = '0;
        if (funct == FUNCT_MFHI) begin
            rd_data = hi;
        end else if (funct == FUNCT_MFLO) begin
            rd_data = lo;
        end
    end

    mult_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .negate   (negate),
        .commit   (commit),
        .is_signed(is_signed),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer against a plain-arithmetic
// product model with directed timing, stall and reset scenarios.
module tb_mult_sequencer;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [5:0]   funct = 6'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         rd_req = 1'b0;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         done;
    logic         stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_hl = 64'd0;

    mult_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct  (funct),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .rd_req (rd_req),
        .rd_data(rd_data),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic sgn,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one multiply and follows it to its DONE cycle.
    task automatic do_mul(input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [63:0] exp;
        exp = ref_prod(sgn, a, b);
        start = 1'b1;
        funct = sgn ? FUNCT_MULT : FUNCT_MULTU;
        rs_val = a;
        rt_val = b;
        tick;
        start = 1'b0;
        funct = 6'd0;
        for (int n = 1; n <= 33; n++) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            chk({tag, "_early_done"}, 64'(done), 64'd0);
            chk({tag, "_hold"}, {hi, lo}, model_hl);
            tick;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        chk({tag, "_prod"}, {hi, lo}, exp);
        model_hl = exp;
    endtask

    function automatic logic [31:0] pick_op();
        unique case ($urandom_range(0, 3))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] e1, e2;

        // reset state
        tick;
        tick;
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        funct = FUNCT_MFHI;
        rd_req = 1'b1;
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);

        // start with a non-multiply funct is ignored
        start = 1'b1;
        #1;
        chk("idle_nostall", 64'(stall), 64'd0);
        tick;
        chk("bad_funct_ignored", 64'(busy), 64'd0);
        start = 1'b0;
        rd_req = 1'b0;
        tick;

        do_mul(1'b0, 32'd7, 32'd6, "multu7x6");
        chk("m76_hi", {32'd0, hi}, 64'd0);
        chk("m76_lo", {32'd0, lo}, 64'h2A);
        funct = FUNCT_MFLO;
        #1;
        chk("m76_rd_lo", 64'(rd_data), 64'h2A);
        funct = FUNCT_MFHI;
        #1;
        chk("m76_rd_hi", 64'(rd_data), 64'd0);
        tick;

        do_mul(1'b1, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
        chk("m3x5_abs", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        tick;
        do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("max_abs", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, "mult_minneg");
        chk("minneg_abs", {hi, lo}, 64'h4000_0000_0000_0000);
        tick;

        // mflo issued at cycle 2 stalls until DONE and reads the new lo
        a1 = $urandom;
        b1 = $urandom;
        e1 = ref_prod(1'b0, a1, b1);
        start = 1'b1;
        funct = FUNCT_MULTU;
        rs_val = a1;
        rt_val = b1;
        tick;
        start = 1'b0;
        tick;
        rd_req = 1'b1;
        funct = FUNCT_MFLO;
        #1;
        for (int n = 2; n <= 33; n++) begin
            chk("mflo_stall", 64'(stall), 64'd1);
            tick;
        end
        chk("mflo_stall_off", 64'(stall), 64'd0);
        chk("mflo_done", 64'(done), 64'd1);
        chk("mflo_rd", 64'(rd_data), {32'd0, e1[31:0]});
        model_hl = e1;
        rd_req = 1'b0;
        tick;

        // start while busy is held off, then accepted in DONE
        a1 = $urandom;
        b1 = $urandom;
        a2 = pick_op();
        b2 = pick_op();
        e1 = ref_prod(1'b0, a1, b1);
        e2 = ref_prod(1'b1, a2, b2);
        start = 1'b1;
        funct = FUNCT_MULTU;
        rs_val = a1;
        rt_val = b1;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 4; n++) tick;
        start = 1'b1;
        funct = FUNCT_MULT;
        rs_val = a2;
        rt_val = b2;
        #1;
        for (int n = 5; n <= 33; n++) begin
            chk("busy_start_stall", 64'(stall), 64'd1);
            chk("busy_start_nodone", 64'(done), 64'd0);
            tick;
        end
        chk("first_done", 64'(done), 64'd1);
        chk("first_prod", {hi, lo}, e1);
        chk("held_start_nostall", 64'(stall), 64'd0);
        model_hl = e1;
        tick;
        start = 1'b0;
        funct = 6'd0;
        for (int n = 1; n <= 33; n++) begin
            chk("second_nodone", 64'(done), 64'd0);
            tick;
        end
        chk("second_done", 64'(done), 64'd1);
        chk("second_prod", {hi, lo}, e2);
        model_hl = e2;
        tick;

        // reset mid-run discards the product
        start = 1'b1;
        funct = FUNCT_MULTU;
        rs_val = $urandom;
        rt_val = $urandom;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 9; n++) tick;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        model_hl = 64'd0;
        tick;
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            chk("midrst_nodone", 64'(done), 64'd0);
            tick;
        end
        do_mul(1'b1, $urandom, $urandom, "after_rst");

        // randomized back-to-back products
        for (int i = 0; i < 8; i++) begin
            do_mul(1'($urandom_range(0, 1)), pick_op(), pick_op(), "rand");
        end
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
